fp16_align_stage: RTL

FP16_ALIGN_STAGE -- requirements
Module: fp16_align_stage

---
 rtl/fp16_align_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fp16_align_stage.sv
// Two-stage binary16 operand alignment ahead of a floating-point adder.
// Latency 2 cycles, one pair per cycle; stage A unpacks/classifies/swaps, stage B aligns.
// Backpressure: the pipeline stalls when out_ready73 is low. in_ready73 falls only once both stages hold data.
module fp16_align_stage #(
  parameter int SUBNORM_EN = 1
) (
  input  logic        clk73,
  input  logic        reset73,
  input  logic        in_valid73,
  output logic        in_ready73,
  input  logic [15:0] Number173,
  input  logic [15:0] Number273,
  output logic        out_valid73,
  input  logic        out_ready73,
  output logic [4:0]  Largerexp73,
  output logic [13:0] Lmantissa73,
  output logic [13:0] Smantissa73,
  output logic        Lsign73,
  output logic        effsub73,
  output logic        special73,
  output logic [15:0] specialres73
);

  // ---------------- handshake ----------------
  logic r_a_vld;
  logic r_b_vld;
  logic w_b_adv;
  logic w_a_adv;

  // Stage B moves when its content is taken or it is empty; A moves whenever B can absorb it.
  // Reset blocks acceptance so nothing enters during the reset cycle.
  assign w_b_adv    = out_ready73 | ~r_b_vld;
  assign w_a_adv    = ~reset73 & (w_b_adv | ~r_a_vld);
  assign in_ready73 = w_a_adv;

  // ---------------- stage A: unpack, classify, swap ----------------
  logic [4:0]  w_e1, w_e2;
  logic [9:0]  w_f1, w_f2;
  logic [10:0] w_sig1, w_sig2;
  logic [4:0]  w_x1, w_x2;
  logic        w_swap;
  logic        w_nan1, w_nan2, w_inf1, w_inf2;
  logic        w_special;
  logic [15:0] w_specres;

  assign w_e1 = Number173[14:10];
  assign w_f1 = Number173[9:0];
  assign w_e2 = Number273[14:10];
  assign w_f2 = Number273[9:0];

  // Subnormals keep their fraction with a zero hidden bit, or flush to zero when disabled.
  assign w_sig1 = (w_e1 != 5'd0) ? {1'b1, w_f1} : ((SUBNORM_EN != 0) ? {1'b0, w_f1} : 11'd0);
  assign w_sig2 = (w_e2 != 5'd0) ? {1'b1, w_f2} : ((SUBNORM_EN != 0) ? {1'b0, w_f2} : 11'd0);
  assign w_x1   = (w_e1 == 5'd0) ? 5'd1 : w_e1;
  assign w_x2   = (w_e2 == 5'd0) ? 5'd1 : w_e2;

  // Magnitude order of binary16 equals unsigned order of bits [14:0]; ties keep Number173 as larger.
  assign w_swap = (Number273[14:0] > Number173[14:0]);

  assign w_nan1 = (w_e1 == 5'd31) && (w_f1 != 10'd0);
  assign w_nan2 = (w_e2 == 5'd31) && (w_f2 != 10'd0);
  assign w_inf1 = (w_e1 == 5'd31) && (w_f1 == 10'd0);
  assign w_inf2 = (w_e2 == 5'd31) && (w_f2 == 10'd0);
  assign w_special = w_nan1 | w_nan2 | w_inf1 | w_inf2;

  // Special result: NaN wins, opposite infinities give the canonical NaN, else pass the infinity.
  always_comb begin
    w_specres = 16'h0000;
    if (w_nan1 || w_nan2) begin
      w_specres = 16'h7E00;
    end else if (w_inf1 && w_inf2 && (Number173[15] != Number273[15])) begin
      w_specres = 16'h7E00;
    end else if (w_inf1) begin
      w_specres = Number173;
    end else if (w_inf2) begin
      w_specres = Number273;
    end
  end

  logic [4:0]  r_a_expL, r_a_expS;
  logic [10:0] r_a_sigL, r_a_sigS;
  logic        r_a_signL, r_a_effsub, r_a_special;
  logic [15:0] r_a_specres;

  // Stage A register: capture the ordered operand pair whenever the stage advances.
  always_ff @(posedge clk73) begin
    if (reset73) begin
      r_a_vld     <= 1'b0;
      r_a_expL    <= 5'd0;
      r_a_expS    <= 5'd0;
      r_a_sigL    <= 11'd0;
      r_a_sigS    <= 11'd0;
      r_a_signL   <= 1'b0;
      r_a_effsub  <= 1'b0;
      r_a_special <= 1'b0;
      r_a_specres <= 16'h0000;
    end else if (w_a_adv) begin
      r_a_vld     <= in_valid73;
      r_a_expL    <= w_swap ? w_x2 : w_x1;
      r_a_expS    <= w_swap ? w_x1 : w_x2;
      r_a_sigL    <= w_swap ? w_sig2 : w_sig1;
      r_a_sigS    <= w_swap ? w_sig1 : w_sig2;
      r_a_signL   <= w_swap ? Number273[15] : Number173[15];
      r_a_effsub  <= Number173[15] ^ Number273[15];
      r_a_special <= w_special;
      r_a_specres <= w_specres;
    end
  end

  // ---------------- stage B: align ----------------
  logic [4:0]  w_d;
  logic [27:0] w_full;
  logic [13:0] w_smant;

  // The low 14 bits of the widened shift catch everything pushed past the LSB for the sticky OR.
  assign w_d     = r_a_expL - r_a_expS;
  assign w_full  = {r_a_sigS, 3'b000, 14'd0} >> w_d;
  assign w_smant = (w_d >= 5'd14) ? {13'd0, |r_a_sigS}
                                  : {w_full[27:15], w_full[14] | (|w_full[13:0])};

  logic [4:0]  r_b_exp;
  logic [13:0] r_b_lm, r_b_sm;
  logic        r_b_sign, r_b_effsub, r_b_special;
  logic [15:0] r_b_specres;

  // Stage B register: outputs update only on advance, so they hold while stalled.
  always_ff @(posedge clk73) begin
    if (reset73) begin
      r_b_vld     <= 1'b0;
      r_b_exp     <= 5'd0;
      r_b_lm      <= 14'd0;
      r_b_sm      <= 14'd0;
      r_b_sign    <= 1'b0;
      r_b_effsub  <= 1'b0;
      r_b_special <= 1'b0;
      r_b_specres <= 16'h0000;
    end else if (w_b_adv) begin
      r_b_vld     <= r_a_vld;
      r_b_exp     <= r_a_expL;
      r_b_lm      <= {r_a_sigL, 3'b000};
      r_b_sm      <= w_smant;
      r_b_sign    <= r_a_signL;
      r_b_effsub  <= r_a_effsub;
      r_b_special <= r_a_special;
      r_b_specres <= r_a_specres;
    end
  end

  assign out_valid73  = r_b_vld;
  assign Largerexp73  = r_b_exp;
  assign Lmantissa73  = r_b_lm;
  assign Smantissa73  = r_b_sm;
  assign Lsign73      = r_b_sign;
  assign effsub73     = r_b_effsub;
  assign special73    = r_b_special;
  assign specialres73 = r_b_specres;

endmodule
